// File: rtl/dmem_dump_responder.sv
// Data memory for processor_arm: combinational reads and clocked writes on the DM_* port,
// plus a valid/ready dump stream of every word, started by a rising edge on dump.
module dmem_dump_responder #(
   parameter int N     = 64,
   parameter int DEPTH = 32,
   parameter int IDX_W = 5
) (
   input  logic             CLOCK_50,
   input  logic             reset,
   input  logic             DM_writeEnable,
   input  logic [N-1:0]     DM_addr,
   input  logic [N-1:0]     DM_writeData,
   input  logic             DM_readEnable,
   output logic [N-1:0]     DM_readData,
   input  logic             dump,
   output logic             dump_valid,
   input  logic             dump_ready,
   output logic [IDX_W-1:0] dump_idx,
   output logic [N-1:0]     dump_data,
   output logic             dump_busy,
   output logic             dump_done
);

   typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

   logic [N-1:0]     mem [DEPTH];
   logic [IDX_W-1:0] word_idx;
   logic             in_range;
   logic             unused_byte_bits;

   state_t           state_reg, state_next;
   logic [IDX_W-1:0] ptr_reg, ptr_next;
   logic [IDX_W-1:0] ptr_inc;
   logic [N-1:0]     data_reg, data_next;
   logic             dump_q_reg;
   logic             dump_rise;

   assign word_idx         = DM_addr[IDX_W+2:3];
   assign in_range         = ~|DM_addr[N-1:IDX_W+3];
   assign unused_byte_bits = ^DM_addr[2:0];

   // Memory is never cleared; writes land even while reset is held.
   always_ff @(posedge CLOCK_50) begin
      if (DM_writeEnable && in_range)
         mem[word_idx] <= DM_writeData;
   end

   assign DM_readData = (DM_readEnable && in_range) ? mem[word_idx] : '0;

   assign dump_rise = dump & ~dump_q_reg;
   assign ptr_inc   = ptr_reg + IDX_W'(1);

   // dump_q keeps sampling through reset so a level still high afterwards is not a new edge.
   always_ff @(posedge CLOCK_50) begin
      dump_q_reg <= dump;
      if (reset) begin
         state_reg <= IDLE;
         ptr_reg   <= '0;
         data_reg  <= '0;
      end else begin
         state_reg <= state_next;
         ptr_reg   <= ptr_next;
         data_reg  <= data_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      ptr_next   = ptr_reg;
      data_next  = data_reg;
      case (state_reg)
         IDLE: begin
            if (dump_rise) begin
               ptr_next   = '0;
               data_next  = mem[0];
               state_next = STREAM;
            end
         end
         STREAM: begin
            // Next word is loaded on the same edge as the handshake: one word per cycle.
            if (dump_ready) begin
               if (ptr_reg == IDX_W'(DEPTH - 1)) begin
                  state_next = DONE;
               end else begin
                  ptr_next  = ptr_inc;
                  data_next = mem[ptr_inc];
               end
            end
         end
         DONE: begin
            if (!dump)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign dump_valid = (state_reg == STREAM);
   assign dump_busy  = (state_reg == STREAM);
   assign dump_done  = (state_reg == DONE);
   assign dump_idx   = ptr_reg;
   assign dump_data  = data_reg;

endmodule

// File: tb/tb_dmem_dump_responder.sv
// Randomized self-checking bench for dmem_dump_responder against an array model of the
// memory and a per-word expected dump snapshot.
module tb_dmem_dump_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        DM_writeEnable;
   logic [63:0] DM_addr;
   logic [63:0] DM_writeData;
   logic        DM_readEnable;
   logic [63:0] DM_readData;
   logic        dump;
   logic        dump_valid;
   logic        dump_ready;
   logic [4:0]  dump_idx;
   logic [63:0] dump_data;
   logic        dump_busy;
   logic        dump_done;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [63:0] model_mem [32];
   logic [63:0] exp_words [32];

   always #5 clk = ~clk;

   dmem_dump_responder #(.N(64), .DEPTH(32), .IDX_W(5)) dut (
      .CLOCK_50      (clk),
      .reset         (reset),
      .DM_writeEnable(DM_writeEnable),
      .DM_addr       (DM_addr),
      .DM_writeData  (DM_writeData),
      .DM_readEnable (DM_readEnable),
      .DM_readData   (DM_readData),
      .dump          (dump),
      .dump_valid    (dump_valid),
      .dump_ready    (dump_ready),
      .dump_idx      (dump_idx),
      .dump_data     (dump_data),
      .dump_busy     (dump_busy),
      .dump_done     (dump_done)
   );

   function automatic logic [63:0] model_read(input logic [63:0] addr, input logic re);
      if (re && addr[63:8] == 56'd0)
         return model_mem[addr[7:3]];
      return 64'd0;
   endfunction

   function automatic logic [63:0] rand64();
      return {$urandom, $urandom};
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_write(input logic [63:0] addr, input logic [63:0] data);
      DM_writeEnable = 1'b1;
      DM_addr        = addr;
      DM_writeData   = data;
      tick();
      DM_writeEnable = 1'b0;
      if (addr[63:8] == 56'd0)
         model_mem[addr[7:3]] = data;
      $display("write addr=%h data=%h", addr, data);
   endtask

   task automatic preload_random();
      for (int i = 0; i < 32; i++)
         do_write(64'(i) << 3, rand64());
      for (int i = 0; i < 32; i++)
         exp_words[i] = model_mem[i];
   endtask

   // Raises dump from low, consumes the whole stream and checks ordering, hold, latency and DONE.
   task automatic run_dump(input bit random_ready, input bit inject, input string tag);
      int          k = 0;
      int          cyc;
      bit          hold = 0;
      logic [4:0]  hidx = '0;
      logic [63:0] hdata = '0;
      DM_readEnable = 1'b0;
      dump_ready    = 1'b1;
      dump          = 1'b1;
      tick();
      cyc = 1;
      n_checks++;
      if (dump_valid !== 1'b1 || dump_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_first_valid: valid=%b busy=%b expected 1 1", tag, dump_valid, dump_busy);
      end
      while (dump_done !== 1'b1 && cyc < 400) begin
         dump_ready     = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         DM_writeEnable = 1'b0;
         n_checks++;
         if (dump_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_valid_gap: valid=%b expected 1 at cycle %0d", tag, dump_valid, cyc);
         end
         if (hold) begin
            n_checks++;
            if (dump_idx !== hidx || dump_data !== hdata) begin
               n_fail++;
               $display("FAIL %s_hold: idx=%0d data=%h expected %0d %h", tag, dump_idx, dump_data, hidx, hdata);
            end
         end
         if (dump_valid === 1'b1 && dump_ready) begin
            n_checks++;
            if (dump_idx !== 5'(k) || dump_data !== exp_words[k[4:0]]) begin
               n_fail++;
               $display("FAIL %s_word: idx=%0d data=%h expected %0d %h", tag, dump_idx, dump_data, k, exp_words[k[4:0]]);
            end
            $display("dump %s word idx=%0d data=%h", tag, dump_idx, dump_data);
            if (inject) begin
               if (dump_idx == 5'd5) begin
                  DM_writeEnable = 1'b1; DM_addr = 64'd3 << 3; DM_writeData = 64'h55; model_mem[3] = 64'h55;
               end else if (dump_idx == 5'd6) begin
                  DM_writeEnable = 1'b1; DM_addr = 64'd20 << 3; DM_writeData = 64'h55; model_mem[20] = 64'h55;
               end else if (dump_idx == 5'd7) begin
                  DM_writeEnable = 1'b1; DM_addr = 64'd8 << 3; DM_writeData = 64'h55; model_mem[8] = 64'h55;
               end
            end
            k++;
            hold = 0;
         end else begin
            hold  = 1;
            hidx  = dump_idx;
            hdata = dump_data;
         end
         tick();
         cyc++;
      end
      DM_writeEnable = 1'b0;
      n_checks++;
      if (k != 32 || dump_done !== 1'b1 || dump_valid !== 1'b0 || dump_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_end: words=%0d done=%b valid=%b busy=%b expected 32 1 0 0", tag, k, dump_done, dump_valid, dump_busy);
      end
      if (!random_ready) begin
         n_checks++;
         if (cyc != 33) begin
            n_fail++;
            $display("FAIL %s_latency: done at cycle %0d expected 33", tag, cyc);
         end
      end
      tick();
      tick();
      n_checks++;
      if (dump_done !== 1'b1 || dump_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_done_hold: done=%b valid=%b expected 1 0", tag, dump_done, dump_valid);
      end
      dump = 1'b0;
      tick();
      n_checks++;
      if (dump_done !== 1'b0 || dump_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_idle: done=%b valid=%b expected 0 0", tag, dump_done, dump_valid);
      end
      $display("dump %s complete words=%0d cycles=%0d", tag, k, cyc);
   endtask

   task automatic test_reset();
      logic [63:0] d;
      reset = 1'b1; dump = 1'b0; dump_ready = 1'b0;
      DM_writeEnable = 1'b0; DM_readEnable = 1'b0; DM_addr = '0; DM_writeData = '0;
      tick();
      tick();
      n_checks++;
      if (dump_valid !== 1'b0 || dump_busy !== 1'b0 || dump_done !== 1'b0 || dump_idx !== 5'd0 || dump_data !== 64'd0) begin
         n_fail++;
         $display("FAIL reset_state: valid=%b busy=%b done=%b idx=%0d data=%h expected all 0",
                  dump_valid, dump_busy, dump_done, dump_idx, dump_data);
      end
      d = rand64();
      do_write(64'd7 << 3, d);
      reset = 1'b0;
      tick();
      DM_addr = 64'd7 << 3; DM_readEnable = 1'b1;
      #1;
      n_checks++;
      if (DM_readData !== d) begin
         n_fail++;
         $display("FAIL reset_write: got %h expected %h", DM_readData, d);
      end
      DM_readEnable = 1'b0;
      $display("reset checked");
   endtask

   task automatic test_write_read();
      logic [63:0] old_v, new_v, a;
      preload_random();
      do_write(64'h10, 64'hDEAD_BEEF_0000_0001);
      DM_addr = 64'h10; DM_readEnable = 1'b1;
      #1;
      n_checks++;
      if (DM_readData !== 64'hDEAD_BEEF_0000_0001) begin
         n_fail++;
         $display("FAIL read_0x10: got %h expected %h", DM_readData, 64'hDEAD_BEEF_0000_0001);
      end
      DM_readEnable = 1'b0;
      #1;
      n_checks++;
      if (DM_readData !== 64'd0) begin
         n_fail++;
         $display("FAIL read_disabled: got %h expected 0", DM_readData);
      end
      // write and read of the same word in one cycle
      old_v = model_mem[2];
      new_v = rand64();
      DM_writeEnable = 1'b1; DM_writeData = new_v; DM_addr = 64'h13; DM_readEnable = 1'b1;
      #1;
      n_checks++;
      if (DM_readData !== old_v) begin
         n_fail++;
         $display("FAIL same_cycle_old: got %h expected %h", DM_readData, old_v);
      end
      tick();
      model_mem[2] = new_v;
      DM_writeEnable = 1'b0;
      #1;
      n_checks++;
      if (DM_readData !== new_v) begin
         n_fail++;
         $display("FAIL same_cycle_new: got %h expected %h", DM_readData, new_v);
      end
      DM_readEnable = 1'b0;
      for (int i = 0; i < 20; i++) begin
         a = {56'd0, 5'($urandom), 3'($urandom)};
         do_write(a, rand64());
         a = {56'd0, 5'($urandom), 3'($urandom)};
         DM_addr = a; DM_readEnable = 1'b1;
         #1;
         n_checks++;
         if (DM_readData !== model_read(a, 1'b1)) begin
            n_fail++;
            $display("FAIL rand_read: addr=%h got %h expected %h", a, DM_readData, model_read(a, 1'b1));
         end
         $display("read addr=%h data=%h", a, DM_readData);
         DM_readEnable = 1'b0;
      end
   endtask

   task automatic test_out_of_range();
      logic [63:0] a;
      do_write(64'h1000, rand64());
      do_write(64'h8000_0000_0000_0008, rand64());
      DM_addr = 64'h1000; DM_readEnable = 1'b1;
      #1;
      n_checks++;
      if (DM_readData !== 64'd0) begin
         n_fail++;
         $display("FAIL oor_read: got %h expected 0", DM_readData);
      end
      for (int i = 0; i < 32; i++) begin
         a = 64'(i) << 3;
         DM_addr = a;
         #1;
         n_checks++;
         if (DM_readData !== model_mem[i]) begin
            n_fail++;
            $display("FAIL oor_unchanged: word %0d got %h expected %h", i, DM_readData, model_mem[i]);
         end
      end
      DM_readEnable = 1'b0;
      $display("out-of-range checked");
   endtask

   task automatic test_dump_stream();
      for (int i = 0; i < 32; i++)
         do_write(64'(i) << 3, 64'(i * 3));
      for (int i = 0; i < 32; i++)
         exp_words[i] = 64'(i * 3);
      run_dump(1'b0, 1'b0, "stream");
   endtask

   task automatic test_back_pressure();
      for (int i = 0; i < 32; i++)
         exp_words[i] = 64'(i * 3);
      run_dump(1'b1, 1'b0, "backpressure");
      preload_random();
      run_dump(1'b1, 1'b0, "backpressure_rand");
   endtask

   task automatic test_reset_abort();
      int guard = 0;
      preload_random();
      dump_ready = 1'b1;
      dump = 1'b1;
      tick();
      while (dump_idx !== 5'd10 && guard < 40) begin
         tick();
         guard++;
      end
      n_checks++;
      if (dump_idx !== 5'd10 || dump_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_reach: idx=%0d valid=%b expected 10 1", dump_idx, dump_valid);
      end
      reset = 1'b1;
      tick();
      n_checks++;
      if (dump_valid !== 1'b0 || dump_busy !== 1'b0 || dump_idx !== 5'd0 || dump_done !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_state: valid=%b busy=%b idx=%0d done=%b expected 0 0 0 0",
                  dump_valid, dump_busy, dump_idx, dump_done);
      end
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++;
         if (dump_valid !== 1'b0 || dump_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_restart: valid=%b busy=%b expected 0 0", dump_valid, dump_busy);
         end
      end
      dump = 1'b0;
      tick();
      $display("abort checked, restarting");
      run_dump(1'b0, 1'b0, "restart");
   endtask

   task automatic test_dump_writes();
      preload_random();
      // word 3 already sent, word 20 still ahead, word 8 loaded on the write edge itself
      exp_words[20] = 64'h55;
      run_dump(1'b0, 1'b1, "dump_writes");
      DM_readEnable = 1'b1;
      for (int i = 0; i < 3; i++) begin
         DM_addr = (i == 0) ? 64'd3 << 3 : (i == 1) ? 64'd20 << 3 : 64'd8 << 3;
         #1;
         n_checks++;
         if (DM_readData !== 64'h55) begin
            n_fail++;
            $display("FAIL dump_write_mem: addr=%h got %h expected 55", DM_addr, DM_readData);
         end
      end
      DM_readEnable = 1'b0;
   endtask

   task automatic test_random_rw();
      logic [63:0] a;
      for (int i = 0; i < 40; i++) begin
         a = {56'd0, 5'($urandom), 3'($urandom)};
         if ($urandom_range(0, 9) == 0)
            a = a | (64'd1 << $urandom_range(8, 63));
         if ($urandom_range(0, 1) == 1) begin
            do_write(a, rand64());
         end else begin
            DM_addr = a; DM_readEnable = 1'($urandom_range(0, 3) != 0);
            #1;
            n_checks++;
            if (DM_readData !== model_read(a, DM_readEnable)) begin
               n_fail++;
               $display("FAIL rand_rw: addr=%h re=%b got %h expected %h", a, DM_readEnable, DM_readData,
                        model_read(a, DM_readEnable));
            end
            $display("read addr=%h re=%b data=%h", a, DM_readEnable, DM_readData);
            DM_readEnable = 1'b0;
            tick();
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_write_read();
      test_out_of_range();
      test_dump_stream();
      test_back_pressure();
      test_reset_abort();
      test_dump_writes();
      test_random_rw();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
